// File: rtl/pc_pkg.sv
// pc_pkg: shared command encoding and priority decode for the program counter.
package pc_pkg;
  localparam int ADDR_W_DEF = 13;
  typedef enum logic [2:0] {CMD_NONE, CMD_INC, CMD_LOAD, CMD_CALL, CMD_RET} cmd_e;
  function automatic cmd_e decode_cmd(input logic stall, input logic ret, input logic call,
                                      input logic load, input logic inc);
    return stall ? CMD_NONE : ret ? CMD_RET : call ? CMD_CALL : load ? CMD_LOAD :
           inc ? CMD_INC : CMD_NONE;
  endfunction
endpackage

// File: rtl/pc_ras.sv
// pc_ras: return-address LIFO; storage is unreset, only the count resets.
module pc_ras #(
  parameter int ADDR_W = 13,
  parameter int STACK_DEPTH = 8,
  localparam int CW = $clog2(STACK_DEPTH + 1),
  localparam int IW = $clog2(STACK_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] data_i,
  output logic [ADDR_W-1:0] data_o,
  output logic [CW-1:0]     count_o,
  output logic              full_o,
  output logic              empty_o
);
  logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] top_idx, wr_idx;
  assign full_o  = count_q == CW'(STACK_DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign wr_idx  = IW'(count_q);
  assign top_idx = IW'(count_q - CW'(1));
  assign data_o  = mem_q[top_idx];
  always_comb count_d = (push_i && !full_o) ? count_q + CW'(1) :
                        (pop_i && !empty_o) ? count_q - CW'(1) : count_q;
  always_ff @(posedge clk)
    if (push_i && !full_o) mem_q[wr_idx] <= data_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count_q <= '0;
    else count_q <= count_d;
endmodule

// File: rtl/pc_ras_unit.sv
// pc_ras_unit: program counter with call/return stack, stall and sticky stack errors.
module pc_ras_unit
  import pc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               stall,
  input  logic                               inc,
  input  logic                               load_en,
  input  logic [ADDR_W-1:0]                  load_addr,
  input  logic                               call_en,
  input  logic                               ret_en,
  input  logic                               clear_err,
  output logic [ADDR_W-1:0]                  pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_count,
  output logic                               stack_full,
  output logic                               stack_empty,
  output logic                               overflow_err,
  output logic                               underflow_err
);
  cmd_e cmd;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, top;
  logic ovf_q, ovf_d, udf_q, udf_d, push, pop, clr;
  assign cmd    = decode_cmd(stall, ret_en, call_en, load_en, inc);
  assign pc_inc = pc_q + ADDR_W'(1);
  assign push   = cmd == CMD_CALL && !stack_full;
  assign pop    = cmd == CMD_RET && !stack_empty;
  assign clr    = clear_err && !stall;
  pc_ras #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) u_ras (
    .clk(clk), .rst_n(rst_n), .push_i(push), .pop_i(pop), .data_i(pc_inc),
    .data_o(top), .count_o(stack_count), .full_o(stack_full), .empty_o(stack_empty)
  );
  // A blocked call/ret leaves pc alone; the error set outranks a same-cycle clear.
  always_comb begin
    pc_d  = pop ? top : push ? load_addr : cmd == CMD_LOAD ? load_addr :
            cmd == CMD_INC ? pc_inc : pc_q;
    ovf_d = (cmd == CMD_CALL && stack_full) || (ovf_q && !clr);
    udf_d = (cmd == CMD_RET && stack_empty) || (udf_q && !clr);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc_q  <= RESET_VEC;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  assign pc            = pc_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = udf_q;
endmodule

// File: tb/tb_pc_ras_unit.sv
// tb_pc_ras_unit: scoreboard bench; a reference model pushes expected state per cycle.
module tb_pc_ras_unit;
  localparam logic [12:0] RV = 13'h0100;
  typedef struct { string nm; logic [20:0] v; } exp_t;
  logic clk = 0, rst_n = 0, stall = 0, inc = 0, load_en = 0, call_en = 0, ret_en = 0, clear_err = 0;
  logic [12:0] load_addr = '0, pc;
  logic [3:0] stack_count;
  logic stack_full, stack_empty, overflow_err, underflow_err;
  logic [20:0] obs;
  exp_t exp_q[$], e;
  logic [12:0] m_pc, m_stk[$];
  logic m_ovf, m_udf;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  pc_ras_unit #(.ADDR_W(13), .STACK_DEPTH(8), .RESET_VEC(RV)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .inc(inc), .load_en(load_en),
    .load_addr(load_addr), .call_en(call_en), .ret_en(ret_en), .clear_err(clear_err),
    .pc(pc), .stack_count(stack_count), .stack_full(stack_full), .stack_empty(stack_empty),
    .overflow_err(overflow_err), .underflow_err(underflow_err));
  assign obs = {pc, stack_count, stack_full, stack_empty, overflow_err, underflow_err};

  function automatic logic [20:0] model_vec();
    return {m_pc, 4'(m_stk.size()), m_stk.size() == 8, m_stk.size() == 0, m_ovf, m_udf};
  endfunction

  task automatic model_reset();
    m_pc = RV; m_stk.delete(); m_ovf = 0; m_udf = 0;
  endtask

  task automatic drive(input string nm, input logic s, input logic i, input logic l,
                       input logic c, input logic r, input logic ce, input logic [12:0] a);
    logic so, su;
    {stall, inc, load_en, call_en, ret_en, clear_err, load_addr} = {s, i, l, c, r, ce, a};
    @(posedge clk);
    if (!s) begin
      so = 0; su = 0;
      if (r) begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back(); else su = 1;
      end else if (c) begin
        if (m_stk.size() == 8) so = 1; else begin m_stk.push_back(m_pc + 13'd1); m_pc = a; end
      end else if (l) m_pc = a;
      else if (i) m_pc = m_pc + 13'd1;
      m_ovf = so | (m_ovf & ~ce);
      m_udf = su | (m_udf & ~ce);
    end
    exp_q.push_back('{nm, model_vec()});
    @(negedge clk);
    {stall, inc, load_en, call_en, ret_en, clear_err} = '0;
  endtask

  task automatic test_reset();
    rst_n = 0; model_reset();
    #12;
    n_cmp++;
    if (obs !== model_vec()) begin n_bad++; $display("FAIL reset: got %h want %h", obs, model_vec()); end
    @(negedge clk) rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      drive("inc_seq", 0, 1, 0, 0, 0, 0, '0);
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %h want %h", e.nm, obs, e.v); end
    end
  endtask

  task automatic test_wrap();
    drive("load_1fff", 0, 0, 1, 0, 0, 0, 13'h1FFF);
    drive("inc_wrap", 0, 1, 0, 0, 0, 0, '0);
    while (exp_q.size() > 1) void'(exp_q.pop_front());
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %h want %h", e.nm, obs, e.v); end
  endtask

  task automatic test_call_ret();
    drive("load_10", 0, 0, 1, 0, 0, 0, 13'h0010);
    void'(exp_q.pop_front());
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: drive("call_200", 0, 0, 0, 1, 0, 0, 13'h0200);
        1, 2: drive("inc_in_sub", 0, 1, 0, 0, 0, 0, '0);
        default: drive("ret_11", 0, 0, 0, 0, 1, 0, '0);
      endcase
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %h want %h", e.nm, obs, e.v); end
    end
  endtask

  task automatic test_overflow();
    drive("load_300", 0, 0, 1, 0, 0, 0, 13'h0300);
    void'(exp_q.pop_front());
    for (int k = 0; k < 8; k++) begin
      drive("nested_call", 0, 0, 0, 1, 0, 0, 13'h0400 + 13'(k * 16));
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %h want %h", e.nm, obs, e.v); end
    end
    drive("call_full", 0, 0, 0, 1, 0, 0, 13'h0AAA);
    drive("clear_ovf", 0, 0, 0, 0, 0, 1, '0);
    for (int k = 0; k < 8; k++) drive("lifo_ret", 0, 0, 0, 0, 1, 0, '0);
    for (int k = 0; k < 10; k++) begin
      e = exp_q.pop_front();
      if (k == 0 || k == 1 || k == 9) begin
        n_cmp++;
        if (e.v[20:8] === 13'bx) begin n_bad++; $display("FAIL %s: model undefined", e.nm); end
      end
    end
    drive("tail_check", 0, 0, 0, 0, 0, 0, '0);
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %h want %h", e.nm, obs, e.v); end
  endtask

  task automatic test_overflow_stepwise();
    for (int k = 0; k < 8; k++) drive("refill", 0, 0, 0, 1, 0, 0, 13'h0800 + 13'(k));
    repeat (8) void'(exp_q.pop_front());
    for (int k = 0; k < 10; k++) begin
      if (k == 0) drive("call_full_aaa", 0, 0, 0, 1, 0, 0, 13'h0AAA);
      else if (k == 1) drive("clear_ovf", 0, 0, 0, 0, 0, 1, '0);
      else drive("ret_lifo", 0, 0, 0, 0, 1, 0, '0);
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %h want %h", e.nm, obs, e.v); end
    end
  endtask

  task automatic test_underflow();
    drive("load_42", 0, 0, 1, 0, 0, 0, 13'h0042);
    void'(exp_q.pop_front());
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: drive("ret_empty", 0, 0, 0, 0, 1, 0, '0);
        1: drive("clr_and_ret_empty", 0, 0, 0, 0, 1, 1, '0);
        default: drive("clr_only", 0, 0, 0, 0, 0, 1, '0);
      endcase
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %h want %h", e.nm, obs, e.v); end
    end
  endtask

  task automatic test_priority();
    drive("pre_ret_err", 0, 0, 0, 0, 1, 0, '0);
    void'(exp_q.pop_front());
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: drive("stall_all", 1, 1, 0, 1, 0, 1, 13'h0500);
        1: drive("call_over_load_inc", 0, 1, 1, 1, 0, 0, 13'h0500);
        2: drive("ret_over_call", 0, 0, 0, 1, 1, 0, 13'h0700);
        default: drive("load_over_inc", 0, 1, 1, 0, 0, 0, 13'h0123);
      endcase
      e = exp_q.pop_front(); n_cmp++;
      if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %h want %h", e.nm, obs, e.v); end
    end
  endtask

  task automatic test_async_reset();
    drive("call_before_rst", 0, 0, 0, 1, 0, 0, 13'h0600);
    void'(exp_q.pop_front());
    inc = 1;
    #2 rst_n = 0;
    model_reset();
    #1;
    n_cmp++;
    if (obs !== model_vec()) begin n_bad++; $display("FAIL async_reset: got %h want %h", obs, model_vec()); end
    inc = 0;
    @(negedge clk) rst_n = 1;
    drive("first_after_rst", 0, 1, 0, 0, 0, 0, '0);
    e = exp_q.pop_front(); n_cmp++;
    if (obs !== e.v) begin n_bad++; $display("FAIL %s: got %h want %h", e.nm, obs, e.v); end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_call_ret();
    test_overflow();
    test_overflow_stepwise();
    test_underflow();
    test_priority();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pc_ras_unit.md
Name: pc_ras_unit

Overview:
- Next-generation program counter for the multi-cycle CPU, parametrised in address width.
- Adds a hardware return-address stack (RAS) supporting call and return, a stall, and sticky stack-error flags.
- Sits between the control FSM (which issues the inc/load/call/ret strobes) and instruction memory (which consumes pc).

Parameters:
- ADDR_W, 13, width of the PC, load target and stack entries.
- STACK_DEPTH, 8, number of RAS entries (>=2).
- RESET_VEC, 0, PC value after reset (ADDR_W bits).

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  freeze all state this cycle.
- inc  in  1  pc <= pc+1.
- load_en  in  1  pc <= load_addr (jump).
- load_addr  in  ADDR_W  jump/call target.
- call_en  in  1  push pc+1, pc <= load_addr.
- ret_en  in  1  pop top of stack into pc.
- clear_err  in  1  clear sticky error flags.
- pc  out  ADDR_W  current program counter (registered).
- stack_count  out  $clog2(STACK_DEPTH+1)  valid RAS entries.
- stack_full  out  1  stack_count == STACK_DEPTH.
- stack_empty  out  1  stack_count == 0.
- overflow_err  out  1  sticky: call attempted while full.
- underflow_err  out  1  sticky: return attempted while empty.

Behaviour:
- Reset (rst_n low, async): pc=RESET_VEC, stack_count=0, stack_full=0, stack_empty=1, both errors 0. RAS storage is not reset; contents are don't-care.
- Reset mid-operation discards any in-flight command. First active edge after deassertion samples commands normally.
- All updates occur on the rising clk edge. New pc is visible the cycle after the strobe (1-cycle latency). All outputs are registered or derived from stack_count.
- Command priority (one action per cycle): stall > ret_en > call_en > load_en > inc. With no strobe asserted, pc holds.
- stall=1: pc, stack and errors hold. clear_err is also ignored.
- ret_en, stack non-empty: pc <= top entry; stack_count decrements.
- ret_en, stack empty: pc holds; underflow_err <= 1.
- call_en, stack not full: entry[stack_count] <= pc+1; pc <= load_addr; stack_count increments.
- call_en, stack full: whole call suppressed (pc holds, no push); overflow_err <= 1.
- load_en: pc <= load_addr; stack untouched.
- inc: pc <= pc+1.
- Arithmetic: pc+1 is modulo 2^ADDR_W (all-ones wraps to 0). The pushed return address wraps the same way.
- clear_err: both flags <= 0. If a new error occurs in the same cycle, the set wins.
- stack_count never exceeds STACK_DEPTH and never goes below 0.

Decomposition:
- Shared package pc_pkg: command-priority encoding (enum CMD_NONE, CMD_INC, CMD_LOAD, CMD_CALL, CMD_RET) and the default ADDR_W constant.
- Sub-module pc_ras: a LIFO with push/pop/data/count/full/empty, parametrised by ADDR_W and STACK_DEPTH. The top level holds the pc register, the priority decode and the error flags.

Test Plan:
- Reset with RESET_VEC=0x0100, then inc for 3 cycles -> pc=0x0100, 0x0101, 0x0102, 0x0103; stack_empty=1.
- pc=0x1FFF (ADDR_W=13), inc -> pc=0x0000.
- pc=0x0010, call_en with load_addr=0x0200; inc twice; ret_en -> pc=0x0200, 0x0201, 0x0202, then 0x0011; stack_count 1 then 0.
- STACK_DEPTH=8: 8 nested calls -> stack_full=1. 9th call with load_addr=0x0AAA -> pc unchanged, overflow_err=1. clear_err -> overflow_err=0. Then 8 returns restore addresses in LIFO order.
- ret_en while empty at pc=0x0042 -> pc stays 0x0042, underflow_err=1. Same cycle clear_err+ret_en while empty -> underflow_err stays 1.
- call_en+inc+stall together -> nothing changes. Next cycle call_en+load_en+inc -> call executes only (one push, pc=load_addr). Assert rst_n low mid-sequence -> pc=RESET_VEC and stack_count=0 immediately, without waiting for a clock edge.
